// File: rtl/bcd_display_mux_pkg.sv
// rtl/bcd_display_mux_pkg.sv - shared segment patterns and scan digit encodings
// Purpose: constants shared by the display mux top and its segment decoder.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_display_mux_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } dig_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to seven-segment decoder
// Purpose: maps one BCD digit to an active-high segment pattern.
// Ports:
//   i_bcd   in  4  BCD digit; 10-15 decode to a dash
//   i_blank in  1  force all segments off
//   o_seg   out 7  active-high segments {g,f,e,d,c,b,a}
module bcd_to_7seg
  import bcd_display_mux_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_OFF;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - 3-digit time-multiplexed seven-segment driver
// Purpose: snapshots ones/tens/hundreds once per scan frame, scans one digit
// per dwell period with a leading anode-off gap, blanks leading zeros.
// Ports:
//   i_clk       in  1  clock, rising edge
//   i_reset     in  1  asynchronous active-high reset
//   i_ones      in  4  BCD ones digit
//   i_tens      in  4  BCD tens digit
//   i_hundreds  in  4  BCD hundreds digit
//   o_seg       out 7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   o_an        out 3  one-hot {hundreds,tens,ones}, polarity per AN_ACTIVE_LOW
//   o_frame     out 1  one-cycle pulse in the cycle a new snapshot is held
module bcd_display_mux
  import bcd_display_mux_pkg::*;
#(
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_ones,
  input  logic [3:0] i_tens,
  input  logic [3:0] i_hundreds,
  output logic [6:0] o_seg,
  output logic [2:0] o_an,
  output logic       o_frame
);

  // Prescaler is at least one bit wide so DWELL_CYCLES==1 stays legal.
  localparam int             PW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0]  BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [2:0]     AN_OFF     = AN_ACTIVE_LOW  ? 3'b111  : 3'b000;
  localparam logic [6:0]     SEG_DARK   = SEG_ACTIVE_LOW ? 7'h7F   : 7'h00;

  logic [PW-1:0] r_presc;
  dig_e          r_state;
  dig_e          w_state_nxt;
  logic [3:0]    r_snap_ones;
  logic [3:0]    r_snap_tens;
  logic [3:0]    r_snap_hund;
  logic [6:0]    r_seg;
  logic [2:0]    r_an;
  logic          r_frame;

  logic          w_wrap;
  logic          w_in_gap;
  logic          w_snap_take;
  logic [3:0]    w_digit;
  logic          w_lz;
  logic [2:0]    w_an_sel;
  logic [6:0]    w_seg_hi;

  assign w_wrap      = (r_presc == PRESC_LAST);
  assign w_in_gap    = (r_presc < BLANK_END);
  // The wrap leaving HUNDREDS starts a new frame: capture the counter there.
  assign w_snap_take = w_wrap && (r_state == DIG_HUNDREDS);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= DIG_ONES;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next digit plus the selected digit's value, blanking and anode.
  // Illegal encodings behave as ONES.
  always_comb begin
    w_state_nxt = DIG_ONES;
    w_digit     = r_snap_ones;
    w_lz        = 1'b0;
    w_an_sel    = 3'b001;
    case (r_state)
      DIG_ONES: begin
        w_state_nxt = w_wrap ? DIG_TENS : DIG_ONES;
      end
      DIG_TENS: begin
        w_state_nxt = w_wrap ? DIG_HUNDREDS : DIG_TENS;
        w_digit     = r_snap_tens;
        w_lz        = LZ_BLANK && (r_snap_hund == 4'd0) && (r_snap_tens == 4'd0);
        w_an_sel    = 3'b010;
      end
      DIG_HUNDREDS: begin
        w_state_nxt = w_wrap ? DIG_ONES : DIG_HUNDREDS;
        w_digit     = r_snap_hund;
        w_lz        = LZ_BLANK && (r_snap_hund == 4'd0);
        w_an_sel    = 3'b100;
      end
      default: begin
        w_state_nxt = DIG_ONES;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_snap_ones <= 4'd0;
      r_snap_tens <= 4'd0;
      r_snap_hund <= 4'd0;
      r_frame     <= 1'b0;
    end else begin
      r_frame <= w_snap_take;
      if (w_snap_take) begin
        r_snap_ones <= i_ones;
        r_snap_tens <= i_tens;
        r_snap_hund <= i_hundreds;
      end
    end
  end

  bcd_to_7seg u_dec (
    .i_bcd   (w_digit),
    .i_blank (w_lz),
    .o_seg   (w_seg_hi)
  );

  // Segments carry the new digit even during the anode-off gap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_DARK;
    end else begin
      r_an  <= w_in_gap ? AN_OFF : (AN_ACTIVE_LOW ? ~w_an_sel : w_an_sel);
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
    end
  end

  assign o_seg   = r_seg;
  assign o_an    = r_an;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - randomized self-checking bench for bcd_display_mux
module tb_bcd_display_mux;

  localparam int DWELL = 4;
  localparam int BLANK = 1;

  logic       clk;
  logic       reset;
  logic [3:0] in_ones;
  logic [3:0] in_tens;
  logic [3:0] in_hund;
  logic [6:0] seg_lo;
  logic [2:0] an_lo;
  logic       frame_lo;
  logic [6:0] seg_hi;
  logic [2:0] an_hi;
  logic       frame_hi;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles since reset release, and the displayed snapshot (0=ones,1=tens,2=hundreds).
  int         cyc;
  int         snap [3];
  logic [6:0] seg_tab [16];

  bcd_display_mux #(
    .DWELL_CYCLES   (DWELL),
    .BLANK_CYCLES   (BLANK),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1),
    .LZ_BLANK       (1'b1)
  ) u_dut_lo (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_ones     (in_ones),
    .i_tens     (in_tens),
    .i_hundreds (in_hund),
    .o_seg      (seg_lo),
    .o_an       (an_lo),
    .o_frame    (frame_lo)
  );

  bcd_display_mux #(
    .DWELL_CYCLES   (DWELL),
    .BLANK_CYCLES   (BLANK),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0),
    .LZ_BLANK       (1'b1)
  ) u_dut_hi (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_ones     (in_ones),
    .i_tens     (in_tens),
    .i_hundreds (in_hund),
    .o_seg      (seg_hi),
    .o_an       (an_hi),
    .o_frame    (frame_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cyc %0d: got %02h expected %02h", tag, cyc, got, exp);
    end
  endtask

  // Active-high pattern the model expects for a digit position of the current snapshot.
  function automatic logic [6:0] model_seg(input int idx);
    int d;
    bit blank;
    d     = snap[idx];
    blank = 1'b0;
    if (idx == 2)      blank = (d == 0);
    else if (idx == 1) blank = (snap[2] == 0) && (d == 0);
    return blank ? 7'h00 : seg_tab[d];
  endfunction

  function automatic logic [3:0] rand_digit();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 3)  return 4'd0;
    if (r == 9) return 4'(10 + $urandom_range(0, 5));
    return 4'($urandom_range(1, 9));
  endfunction

  task automatic set_in(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    in_hund = h;
    in_tens = t;
    in_ones = o;
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 3; i++) snap[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an_lo"},    {5'd0, an_lo},  {5'd0, 3'b111});
    chk({tag, "_seg_lo"},   {1'b0, seg_lo}, {1'b0, 7'h7F});
    chk({tag, "_frame_lo"}, {7'd0, frame_lo}, 8'd0);
    chk({tag, "_an_hi"},    {5'd0, an_hi},  8'd0);
    chk({tag, "_seg_hi"},   {1'b0, seg_hi}, 8'd0);
    chk({tag, "_frame_hi"}, {7'd0, frame_hi}, 8'd0);
  endtask

  // One clock: outputs after the edge reflect the scan position before it.
  task automatic step();
    int         p;
    int         idx;
    logic [2:0] sel;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic       e_frame;
    @(posedge clk);
    #1;
    p       = cyc % DWELL;
    idx     = (cyc / DWELL) % 3;
    sel     = 3'b001 << idx;
    e_an    = (p < BLANK) ? 3'b111 : ~sel;
    e_seg   = ~model_seg(idx);
    e_frame = (p == DWELL - 1) && (idx == 2);
    if (e_frame) begin
      snap[0] = int'(in_ones);
      snap[1] = int'(in_tens);
      snap[2] = int'(in_hund);
    end
    cyc++;
    chk("an_lo",    {5'd0, an_lo},    {5'd0, e_an});
    chk("seg_lo",   {1'b0, seg_lo},   {1'b0, e_seg});
    chk("frame_lo", {7'd0, frame_lo}, {7'd0, e_frame});
    chk("an_hi",    {5'd0, an_hi},    {5'd0, ~e_an});
    chk("seg_hi",   {1'b0, seg_hi},   {1'b0, ~e_seg});
    chk("frame_hi", {7'd0, frame_hi}, {7'd0, e_frame});
  endtask

  initial begin
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;

    reset = 1'b1;
    set_in(4'd0, 4'd0, 4'd0);
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // First frame shows 000 with leading zeros blanked, then a held 123.
    set_in(4'd1, 4'd2, 4'd3);
    repeat (40) step();

    // Mid-frame input change must not tear the display.
    set_in(4'd5, 4'd6, 4'd7);
    repeat (14) step();
    set_in(4'd8, 4'd8, 4'd8);
    repeat (30) step();

    // Leading-zero and invalid-BCD cases.
    set_in(4'd0, 4'd0, 4'd7);  repeat (28) step();
    set_in(4'd0, 4'd4, 4'd0);  repeat (28) step();
    set_in(4'd0, 4'd0, 4'd0);  repeat (28) step();
    set_in(4'hC, 4'd0, 4'd0);  repeat (28) step();
    set_in(4'd9, 4'd0, 4'hF);  repeat (28) step();

    repeat (600) begin
      if ($urandom_range(0, 4) == 0) set_in(rand_digit(), rand_digit(), rand_digit());
      step();
    end

    // Reset asserted in the middle of a scan.
    repeat (5) step();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    reset = 1'b0;
    model_reset();
    set_in(4'd1, 4'd2, 4'd3);
    repeat (30) step();

    repeat (300) begin
      if ($urandom_range(0, 2) == 0) set_in(rand_digit(), rand_digit(), rand_digit());
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
